wb_dma_arbiter: RTL and testbench
=================================

Name: wb_dma_arbiter

Overview:
- Two-master, one-slave Wishbone B4 arbiter.
- Shares the memory-side slave port (BRAM/DDR bridge) between the CPU data bus (master 0) and the SD controller DMA master port (master 1).
- Round-robin grant, held for a whole cyc cycle so CTI bursts and locked sequences are never split.
- Watchdog on slave acknowledge, so a hung slave cannot stall SD DMA or the CPU forever.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT_CYCLES, 1024, cycles with stb high and no ack/err before timeout error; must be >= 2.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- m0_adr_i / m1_adr_i  in  AW  master address.
- m0_dat_i / m1_dat_i  in  DW  master write data.
- m0_dat_o / m1_dat_o  out  DW  read data to master.
- m0_sel_i / m1_sel_i  in  DW/8  byte select.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  bus request / cycle.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_cti_i / m1_cti_i  in  3  cycle type.
- m0_bte_i / m1_bte_i  in  2  burst type.
- m0_ack_o / m1_ack_o  out  1  acknowledge.
- m0_err_o / m1_err_o  out  1  error (slave error or timeout).
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_sel_o  out  DW/8  slave byte select.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- grant_o  out  2  one-hot current grant, for debug/ILA.

Behaviour:
- State register: IDLE, GNT0, GNT1; plus last-served bit `last`.
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first contention), timeout counter=0, grant_o=00.
  - Every slave output and every master ack/err is 0; m*_dat_o=0.
- IDLE:
  - Neither cyc high: stay in IDLE.
  - One cyc high: go to that master's GNT.
  - Both high: grant the master != last.
  - Arbitration latency is 1 cycle: slave sees cyc/stb on the cycle after the grant register updates.
- GNTn:
  - Slave outputs are a combinational mux of master n's adr/dat/sel/we/cyc/stb/cti/bte.
  - m_n_ack_o = s_ack_i; m_n_dat_o = s_dat_i.
  - The non-granted master sees ack=err=0 and dat_o=0.
- Leaving GNTn: on a clock edge where m_n_cyc_i is sampled low, set last=n. Then:
  - if the other master's cyc is high, go directly to its GNT (zero dead cycles);
  - otherwise go to IDLE.
- Grant is never revoked while the granted cyc stays high. Bursts (cti=010) and cti=111 end-of-burst pass through untouched.
- In IDLE, s_cyc_o=s_stb_o=0 and the other slave outputs are 0.
- Timeout counter (width clog2(TIMEOUT_CYCLES+1)):
  - Increments each cycle in GNTn with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears on ack, err, stb low, or state change.
- When the counter reaches TIMEOUT_CYCLES-1 with no ack:
  - m_n_err_o pulses high for exactly 1 cycle (registered); counter returns to 0.
  - s_stb_o is forced low during that cycle.
  - Grant is held until the master drops cyc.
- m_n_err_o = s_err_i (combinational) OR the timeout pulse.
- Simultaneous ack and timeout threshold: ack wins, no err.
- Master dropping cyc mid-burst with no ack is legal: released next edge, counter cleared.
- Async reset mid-transfer immediately drops s_cyc_o/s_stb_o and all acks; no transaction is replayed.

Decomposition:
- Package wb_arb_pkg: state encoding localparams (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111).
- One sub-module: wb_ack_watchdog (counter + err pulse, parameterised by TIMEOUT_CYCLES).
- The mux lives in the top.

Test Plan:
- Single m1 request: m1 read from adr 0x100, slave acks with 0xDEADBEEF two cycles later -> grant_o=10 one cycle after cyc; m1_dat_o=0xDEADBEEF with m1_ack_o; m0_ack_o stays 0.
- Contention after reset: m0 and m1 raise cyc on the same edge -> grant_o=01 first. When m0 drops cyc with m1 still requesting, grant_o=10 on the next cycle with no IDLE cycle.
- Round-robin fairness: both masters hold cyc continuously for 4 single-beat cycles each -> grants alternate 01,10,01,10.
- Burst integrity: m1 runs an 8-beat INCR burst (cti 010 x7, 111) while m0 requests -> m0 is not granted until m1 drops cyc after the 8th ack; slave sees all 8 beats contiguously.
- Timeout: TIMEOUT_CYCLES=16, slave never acks a m0 write -> m0_err_o is a single pulse on the 16th stb cycle; s_stb_o is low that cycle; m1 is granted after m0 drops cyc.
- Reset mid-burst: assert wb_rst_i during beat 3 of an m1 burst -> s_cyc_o=0, grant_o=00 asynchronously; after release, first contention grants m0.

Source files
------------

// File: rtl/wb_dma_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone B4 arbiter:
//   - arbiter state encoding (IDLE / GNT0 / GNT1)
//   - Wishbone cycle-type (CTI) constants
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_GNT0 = GNT0,
        ST_GNT1 = GNT1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // One-hot grant vector for debug: bit0 = master 0, bit1 = master 1.
    function automatic logic [1:0] grant_onehot(arb_state_e st);
        return {st == ST_GNT1, st == ST_GNT0};
    endfunction

endpackage

// File: rtl/wb_dma_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_dma_arbiter_if
// One Wishbone B4 point-to-point link.
//   master modport : drives adr/dat_w/sel/we/cyc/stb/cti/bte, receives dat_r/ack/err
//   slave  modport : the reverse direction
// dat_w is master-to-slave write data, dat_r is slave-to-master read data.
// -----------------------------------------------------------------------------
interface wb_dma_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_dma_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// wb_ack_watchdog
// Counts consecutive cycles in which the granted master's strobe reaches the
// slave without ack or err. After TIMEOUT_CYCLES-1 such cycles a one-cycle
// registered pulse is produced; during that pulse the top forces s_stb low and
// reports err to the granted master. TIMEOUT_CYCLES must be >= 2.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : grant is changing this cycle; restart from zero
//   wait_i     : strobe presented with no ack/err this cycle
//   ack_i      : slave ack; an ack during the pulse cycle suppresses err
//   pulse_o    : raw timeout pulse (used to force s_stb low)
//   err_o      : timeout error toward the granted master
// -----------------------------------------------------------------------------
module wb_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic wait_i,
    input  logic ack_i,
    output logic pulse_o,
    output logic err_o
);
    localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0]  THRESHOLD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // The pulse is armed one cycle early so it lands on the cycle where the
    // count sits at the threshold. During that cycle s_stb is forced low, so
    // wait_i drops and the counter returns to zero on the following edge.
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (!clr_i && wait_i) begin
            if (cnt_q == LAST_WAIT) begin
                cnt_d   = THRESHOLD;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign pulse_o = pulse_q;
    // A late ack in the pulse cycle wins over the timeout.
    assign err_o   = pulse_q & ~ack_i;

endmodule

// File: rtl/wb_dma_arbiter.sv
// -----------------------------------------------------------------------------
// wb_dma_arbiter
// Two-master / one-slave Wishbone B4 arbiter. Master 0 is the CPU data bus,
// master 1 the SD controller DMA port; the slave is the memory bridge.
// Round-robin between masters, grant held for the full cyc so bursts and
// locked sequences are never split. A watchdog turns a missing slave ack
// into an err pulse toward the granted master.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   m0, m1             : master links (arbiter acts as their slave)
//   s                  : slave link (arbiter acts as its master)
//   grant_o            : one-hot current grant, bit0 = m0, bit1 = m1
// -----------------------------------------------------------------------------
module wb_dma_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_dma_arbiter_if.slave   m0,
    wb_dma_arbiter_if.slave   m1,
    wb_dma_arbiter_if.master  s,
    output logic [1:0]        grant_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;

    // ---------------- grant state register ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;        // m0 wins the first contention
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0.cyc) begin
                    state_d = ST_GNT0;
                end else if (m1.cyc) begin
                    state_d = ST_GNT1;
                end
            end
            // Release only when the owner drops cyc; hand straight over to a
            // waiting master so there is no dead cycle.
            ST_GNT0: begin
                if (!m0.cyc) begin
                    last_d  = 1'b0;
                    state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc) begin
                    last_d  = 1'b1;
                    state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- bus mux ----------------
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [DW/8-1:0] s_sel;
    logic            s_we, s_cyc, s_stb_raw, s_stb;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic [DW-1:0]   m0_dat_r, m1_dat_r;
    logic            m0_ack, m1_ack, m0_err, m1_err;
    logic            tmo_pulse, tmo_err;

    always_comb begin
        s_adr     = '0;
        s_dat_w   = '0;
        s_sel     = '0;
        s_we      = 1'b0;
        s_cyc     = 1'b0;
        s_stb_raw = 1'b0;
        s_cti     = CTI_CLASSIC;
        s_bte     = 2'b00;
        m0_dat_r  = '0;
        m1_dat_r  = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_adr     = m0.adr;
                s_dat_w   = m0.dat_w;
                s_sel     = m0.sel;
                s_we      = m0.we;
                s_cyc     = m0.cyc;
                s_stb_raw = m0.stb;
                s_cti     = m0.cti;
                s_bte     = m0.bte;
                m0_dat_r  = s.dat_r;
                m0_ack    = s.ack;
                m0_err    = s.err | tmo_err;
            end
            ST_GNT1: begin
                s_adr     = m1.adr;
                s_dat_w   = m1.dat_w;
                s_sel     = m1.sel;
                s_we      = m1.we;
                s_cyc     = m1.cyc;
                s_stb_raw = m1.stb;
                s_cti     = m1.cti;
                s_bte     = m1.bte;
                m1_dat_r  = s.dat_r;
                m1_ack    = s.ack;
                m1_err    = s.err | tmo_err;
            end
            default: ;
        endcase
    end

    // Strobe is withheld from the slave in the timeout cycle so the stale
    // access is abandoned rather than completed.
    assign s_stb = s_stb_raw & ~tmo_pulse;

    assign s.adr   = s_adr;
    assign s.dat_w = s_dat_w;
    assign s.sel   = s_sel;
    assign s.we    = s_we;
    assign s.cyc   = s_cyc;
    assign s.stb   = s_stb;
    assign s.cti   = s_cti;
    assign s.bte   = s_bte;

    assign m0.dat_r = m0_dat_r;
    assign m0.ack   = m0_ack;
    assign m0.err   = m0_err;
    assign m1.dat_r = m1_dat_r;
    assign m1.ack   = m1_ack;
    assign m1.err   = m1_err;

    assign grant_o = grant_onehot(state_q);

    // ---------------- ack watchdog ----------------
    wb_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr_i   (state_d != state_q),
        .wait_i  (s_stb & ~s.ack & ~s.err),
        .ack_i   (s.ack),
        .pulse_o (tmo_pulse),
        .err_o   (tmo_err)
    );

endmodule

// File: tb/tb_wb_dma_arbiter.sv
module tb_wb_dma_arbiter;
    import wb_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    always #5 clk = ~clk;

    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) s_if  ();

    wb_dma_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant_o  (grant)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = '0; m0_if.we = 1'b0;
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.cti = '0; m0_if.bte = '0;
        m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = '0; m1_if.we = 1'b0;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = '0; m1_if.bte = '0;
        s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = '0;
    endtask

    // Arbitration table: inputs for one cycle and the outputs expected in it.
    typedef struct {
        bit         c0, c1, ack;
        logic [1:0] g;
        bit         a0, a1, sc;
    } vec_t;
    vec_t tbl[18];

    // Reference model state for the random phase.
    int         own, lst, waits, nxt, ack_pct;
    bit         tmo, waiting, rc0, rc1;
    bit         cyc_v[2], stb_v[2];
    logic [31:0] adr_v[2];
    logic [1:0] e_g;
    int         beats;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        clr_inputs();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; s_if.ack = 1'b1; s_if.dat_r = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_if.cyc, 0);
        chk("rst_s_stb", s_if.stb, 0);
        chk("rst_s_adr", s_if.adr, 0);
        chk("rst_m0_ack", m0_if.ack, 0);
        chk("rst_m0_dat", m0_if.dat_r, 0);
        $display("txn reset: grant=%b s_cyc=%b", grant, s_if.cyc);
        @(posedge clk); #1;
        clr_inputs();
        rst = 1'b0;

        // ---------------- table: contention + round robin ----------------
        tbl[0]  = '{1,1,0, 2'b00, 0,0,0};
        tbl[1]  = '{1,1,1, 2'b01, 1,0,1};
        tbl[2]  = '{0,1,0, 2'b01, 0,0,0};
        tbl[3]  = '{1,1,1, 2'b10, 0,1,1};
        tbl[4]  = '{1,0,0, 2'b10, 0,0,0};
        tbl[5]  = '{1,1,1, 2'b01, 1,0,1};
        tbl[6]  = '{0,1,0, 2'b01, 0,0,0};
        tbl[7]  = '{1,1,1, 2'b10, 0,1,1};
        tbl[8]  = '{1,0,0, 2'b10, 0,0,0};
        tbl[9]  = '{1,1,1, 2'b01, 1,0,1};
        tbl[10] = '{0,1,0, 2'b01, 0,0,0};
        tbl[11] = '{1,1,1, 2'b10, 0,1,1};
        tbl[12] = '{1,0,0, 2'b10, 0,0,0};
        tbl[13] = '{1,1,1, 2'b01, 1,0,1};
        tbl[14] = '{0,1,0, 2'b01, 0,0,0};
        tbl[15] = '{1,1,1, 2'b10, 0,1,1};
        tbl[16] = '{0,0,0, 2'b10, 0,0,0};
        tbl[17] = '{0,0,0, 2'b00, 0,0,0};
        for (int i = 0; i < 18; i++) begin
            m0_if.cyc = tbl[i].c0; m0_if.stb = tbl[i].c0;
            m1_if.cyc = tbl[i].c1; m1_if.stb = tbl[i].c1;
            s_if.ack  = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_m0_ack", i), m0_if.ack, tbl[i].a0);
            chk($sformatf("tbl%0d_m1_ack", i), m1_if.ack, tbl[i].a1);
            chk($sformatf("tbl%0d_s_cyc", i), s_if.cyc, tbl[i].sc);
            $display("txn tbl%0d: cyc=%b%b ack=%b grant=%b", i, tbl[i].c1, tbl[i].c0, tbl[i].ack, grant);
            next_cycle();
        end
        clr_inputs();

        // ---------------- single m1 read ----------------
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h100; m1_if.sel = 4'hF;
        @(negedge clk);
        chk("rd_grant_lat", grant, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("rd_grant", grant, 2'b10);
        chk("rd_s_adr", s_if.adr, 32'h100);
        chk("rd_s_cyc", s_if.cyc, 1);
        chk("rd_m1_ack_early", m1_if.ack, 0);
        next_cycle();
        s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_m1_ack", m1_if.ack, 1);
        chk("rd_m1_dat", m1_if.dat_r, 32'hDEAD_BEEF);
        chk("rd_m0_ack", m0_if.ack, 0);
        chk("rd_m0_dat", m0_if.dat_r, 0);
        $display("txn m1 read adr=0x100 data=%h", m1_if.dat_r);
        next_cycle();
        clr_inputs();
        @(negedge clk);
        chk("rd_hold", grant, 2'b10);
        next_cycle();

        // ---------------- m1 burst while m0 waits ----------------
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.cti = CTI_INCR; m1_if.adr = 32'h200;
        next_cycle();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1; m0_if.adr = 32'h40; m0_if.dat_w = 32'h1234_5678;
        s_if.ack = 1'b1;
        beats = 0;
        for (int b = 0; b < 8; b++) begin
            m1_if.adr = 32'h200 + 32'(4 * b);
            m1_if.cti = (b == 7) ? CTI_EOB : CTI_INCR;
            @(negedge clk);
            chk($sformatf("burst%0d_grant", b), grant, 2'b10);
            chk($sformatf("burst%0d_s_adr", b), s_if.adr, 32'h200 + 32'(4 * b));
            chk($sformatf("burst%0d_s_cti", b), s_if.cti, (b == 7) ? CTI_EOB : CTI_INCR);
            chk($sformatf("burst%0d_m0_ack", b), m0_if.ack, 0);
            if (grant == 2'b10 && s_if.stb && s_if.ack) beats++;
            next_cycle();
        end
        chk("burst_beats", beats, 8);
        $display("txn m1 burst 8 beats from 0x200, slave saw %0d", beats);
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = CTI_CLASSIC; s_if.ack = 1'b0;
        @(negedge clk);
        chk("burst_hold", grant, 2'b10);
        next_cycle();
        @(negedge clk);
        chk("burst_handover", grant, 2'b01);

        // ---------------- timeout on m0 write ----------------
        for (int k = 1; k <= 17; k++) begin
            chk($sformatf("tmo%0d_err", k), m0_if.err, (k == 16));
            chk($sformatf("tmo%0d_stb", k), s_if.stb, (k != 16));
            next_cycle();
            if (k == 1) begin
                m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h300;
            end
            @(negedge clk);
        end
        $display("txn m0 write adr=0x40 timed out");
        next_cycle();
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
        @(negedge clk);
        chk("tmo_hold", grant, 2'b01);
        next_cycle();
        @(negedge clk);
        chk("tmo_m1_granted", grant, 2'b10);

        // ---------------- reset during m1 burst ----------------
        next_cycle();
        s_if.ack = 1'b1; m1_if.cti = CTI_INCR; m1_if.adr = 32'h400;
        @(negedge clk);
        chk("rstb_beat0_ack", m1_if.ack, 1);
        next_cycle(); m1_if.adr = 32'h404;
        next_cycle(); m1_if.adr = 32'h408;
        next_cycle(); m1_if.adr = 32'h40C;
        #2;
        rst = 1'b1;
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h80;
        #1;
        chk("rstb_s_cyc", s_if.cyc, 0);
        chk("rstb_s_stb", s_if.stb, 0);
        chk("rstb_grant", grant, 2'b00);
        chk("rstb_m1_ack", m1_if.ack, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rstb_idle", grant, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("rstb_m0_first", grant, 2'b01);
        chk("rstb_s_adr", s_if.adr, 32'h80);
        $display("txn reset mid-burst, then contention grant=%b", grant);

        // ---------------- randomized vs reference model ----------------
        next_cycle();
        rst = 1'b1;
        clr_inputs();
        next_cycle();
        rst = 1'b0;
        own = -1; lst = 1; waits = 0; tmo = 1'b0; rc0 = 1'b0; rc1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 15) rc0 = !rc0;
            if ($urandom_range(0, 99) < 15) rc1 = !rc1;
            m0_if.cyc = rc0; m0_if.stb = rc0 && ($urandom_range(0, 3) != 0);
            m1_if.cyc = rc1; m1_if.stb = rc1 && ($urandom_range(0, 3) != 0);
            m0_if.adr = $urandom; m1_if.adr = $urandom;
            m0_if.dat_w = $urandom; m1_if.dat_w = $urandom;
            m0_if.cti = 3'($urandom); m1_if.cti = 3'($urandom);
            ack_pct = ((n / 100) % 2 == 1) ? 4 : 50;
            s_if.ack = ($urandom_range(0, 99) < ack_pct);
            s_if.err = !s_if.ack && ($urandom_range(0, 99) < 3);
            s_if.dat_r = $urandom;
            cyc_v[0] = m0_if.cyc; cyc_v[1] = m1_if.cyc;
            stb_v[0] = m0_if.stb; stb_v[1] = m1_if.stb;
            adr_v[0] = m0_if.adr; adr_v[1] = m1_if.adr;
            @(negedge clk);
            e_g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
            chk("rnd_grant", grant, e_g);
            chk("rnd_s_cyc", s_if.cyc, (own >= 0) ? cyc_v[own] : 1'b0);
            chk("rnd_s_stb", s_if.stb, (own >= 0) ? (stb_v[own] && !tmo) : 1'b0);
            chk("rnd_s_adr", s_if.adr, (own >= 0) ? adr_v[own] : 32'h0);
            chk("rnd_m0_ack", m0_if.ack, (own == 0) && s_if.ack);
            chk("rnd_m1_ack", m1_if.ack, (own == 1) && s_if.ack);
            chk("rnd_m0_err", m0_if.err, (own == 0) && (s_if.err || (tmo && !s_if.ack)));
            chk("rnd_m1_err", m1_if.err, (own == 1) && (s_if.err || (tmo && !s_if.ack)));
            chk("rnd_m0_dat", m0_if.dat_r, (own == 0) ? s_if.dat_r : 32'h0);
            chk("rnd_m1_dat", m1_if.dat_r, (own == 1) ? s_if.dat_r : 32'h0);
            // Ownership rules: holder keeps the bus until it drops cyc; a
            // free bus goes to the requester, or to the one not served last.
            waiting = (own >= 0) && stb_v[own] && !tmo && !s_if.ack && !s_if.err;
            nxt = own;
            if (own < 0) begin
                if (cyc_v[0] && cyc_v[1]) nxt = 1 - lst;
                else if (cyc_v[0])        nxt = 0;
                else if (cyc_v[1])        nxt = 1;
            end else if (!cyc_v[own]) begin
                lst = own;
                nxt = cyc_v[1 - own] ? 1 - own : -1;
            end
            if (nxt != own || !waiting) begin
                waits = 0;
                tmo   = 1'b0;
            end else begin
                waits = waits + 1;
                tmo   = (waits == TMO - 1);
            end
            if (nxt != own) $display("txn rnd cycle %0d: grant m%0d -> m%0d", n, own, nxt);
            own = nxt;
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
